// File: rtl/rx_icmp_echo_parse.sv
// Receive-side ICMP echo-request parser: validates and buffers a request, then serves it on AXI-Stream.
// Optional IP header checksum verification is built when ICMP_RX_IP_CKS_CHECK_EN is defined.
module rx_icmp_echo_parse #(
    parameter logic [31:0] FPGA_IP       = 32'hC0A8_006E,
    parameter int          ICMP_DATA_LEN = 32
) (
    input  logic        CLK_125M,
    input  logic        SYS_RST,
    input  logic [7:0]  IP_RX_TDATA,
    input  logic        IP_RX_TVALID,
    input  logic        IP_RX_TLAST,
    output logic        IP_RX_TREADY,
    output logic        TRIG_TX_ICMP,
    output logic [7:0]  RX_ICMP_TDATA,
    output logic        RX_ICMP_TVALID,
    input  logic        RX_ICMP_TREADY,
    output logic        RX_ICMP_TLAST,
    output logic [31:0] RX_ICMP_TUSER,
    output logic [31:0] RX_ICMP_SRC_IP,
    output logic [15:0] DROP_CNT
);

    localparam int                DEPTH     = 7 + ICMP_DATA_LEN;
    localparam int                IDX_W     = $clog2(DEPTH);
    localparam logic [IDX_W-1:0]  FIRST_PTR = '0;
    localparam logic [IDX_W-1:0]  LAST_PTR  = IDX_W'(DEPTH - 1);
    localparam logic [15:0]       TOTAL_LEN = 16'(28 + ICMP_DATA_LEN);
    localparam logic [15:0]       LAST_IDX  = 16'(27 + ICMP_DATA_LEN);

    typedef enum logic [1:0] {
        RECV  = 2'd0,
        DROP  = 2'd1,
        TRIG  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [7:0]        hi_q, hi_d;
    logic [31:0]       sum_q, sum_d;
    logic [31:0]       src_sh_q, src_sh_d;
    logic [31:0]       src_ip_q, src_ip_d;
    logic [15:0]       drop_q, drop_d;
    logic              rdy_q, rdy_d;
    logic              trig_q, trig_d;
    logic              tvalid_q, tvalid_d;
    logic              tlast_q, tlast_d;
    logic [7:0]        tdata_q, tdata_d;
    logic [IDX_W-1:0]  rd_q, rd_d;
    logic [7:0]        mem_q [0:DEPTH-1];

    logic              accept_s;
    logic              xfer_s;
    logic              fail_s;
    logic              wr_en_s;
    logic [IDX_W-1:0]  wr_idx_s;
    logic [IDX_W-1:0]  rd_next_s;
    logic [15:0]       drop_inc_s;
    logic [15:0]       cnt_inc_s;
`ifdef ICMP_RX_IP_CKS_CHECK_EN
    logic [15:0]       csum_q, csum_d;
    logic [16:0]       csum_add_s;
`endif

    // Next-state, parsing checks, buffer write decode and stream output decode
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        sum_d      = sum_q;
        src_sh_d   = src_sh_q;
        src_ip_d   = src_ip_q;
        drop_d     = drop_q;
        trig_d     = 1'b0;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        tdata_d    = tdata_q;
        rd_d       = rd_q;
        wr_en_s    = 1'b0;
        wr_idx_s   = '0;
        fail_s     = 1'b0;
        accept_s   = IP_RX_TVALID && rdy_q;
        xfer_s     = tvalid_q && RX_ICMP_TREADY;
        rd_next_s  = rd_q + IDX_W'(1);
        drop_inc_s = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
        cnt_inc_s  = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
`ifdef ICMP_RX_IP_CKS_CHECK_EN
        csum_d     = csum_q;
        csum_add_s = 17'd0;
`endif
        case (state_q)
            RECV: begin
                if (accept_s) begin
                    hi_d  = IP_RX_TDATA;
                    cnt_d = cnt_inc_s;
                    case (cnt_q)
                        16'd0: begin
                            fail_s = (IP_RX_TDATA != 8'h45);
                            sum_d  = 32'd0;
`ifdef ICMP_RX_IP_CKS_CHECK_EN
                            csum_d = 16'd0;
`endif
                        end
                        16'd2:  fail_s = (IP_RX_TDATA != TOTAL_LEN[15:8]);
                        16'd3:  fail_s = (IP_RX_TDATA != TOTAL_LEN[7:0]);
                        16'd4:  begin wr_en_s = 1'b1; wr_idx_s = IDX_W'(0); end
                        16'd5:  begin wr_en_s = 1'b1; wr_idx_s = IDX_W'(1); end
                        16'd8:  begin wr_en_s = 1'b1; wr_idx_s = IDX_W'(2); end
                        16'd9:  fail_s = (IP_RX_TDATA != 8'h01);
                        16'd12, 16'd13, 16'd14, 16'd15: src_sh_d = {src_sh_q[23:0], IP_RX_TDATA};
                        16'd16: fail_s = (IP_RX_TDATA != FPGA_IP[31:24]);
                        16'd17: fail_s = (IP_RX_TDATA != FPGA_IP[23:16]);
                        16'd18: fail_s = (IP_RX_TDATA != FPGA_IP[15:8]);
                        16'd19: fail_s = (IP_RX_TDATA != FPGA_IP[7:0]);
                        16'd20: fail_s = (IP_RX_TDATA != 8'h08);
                        16'd21: fail_s = (IP_RX_TDATA != 8'h00);
                        16'd24: begin wr_en_s = 1'b1; wr_idx_s = IDX_W'(3); end
                        16'd25: begin wr_en_s = 1'b1; wr_idx_s = IDX_W'(4); end
                        16'd26: begin wr_en_s = 1'b1; wr_idx_s = IDX_W'(5); end
                        16'd27: begin wr_en_s = 1'b1; wr_idx_s = IDX_W'(6); end
                        default: fail_s = 1'b0;
                    endcase
`ifdef ICMP_RX_IP_CKS_CHECK_EN
                    // Odd header bytes close a 16-bit word; fold the carry straight back in
                    if ((cnt_q < 16'd20) && cnt_q[0]) begin
                        csum_add_s = {1'b0, csum_q} + {1'b0, hi_q, IP_RX_TDATA};
                        csum_d     = csum_add_s[15:0] + {15'd0, csum_add_s[16]};
                    end else begin
                        csum_add_s = 17'd0;
                    end
                    fail_s = fail_s || ((cnt_q == 16'd19) && (csum_d != 16'hFFFF));
`endif
                    // Payload lands after the seven header slots; odd bytes complete a big-endian word
                    if ((cnt_q >= 16'd28) && (cnt_q <= LAST_IDX)) begin
                        wr_en_s  = 1'b1;
                        wr_idx_s = IDX_W'(cnt_q - 16'd21);
                        sum_d    = cnt_q[0] ? (sum_q + {16'd0, hi_q, IP_RX_TDATA}) : sum_q;
                    end else begin
                        wr_en_s = wr_en_s;
                    end
                    if (IP_RX_TLAST) begin
                        cnt_d = 16'd0;
                        if (fail_s || (cnt_q < LAST_IDX)) begin
                            drop_d  = drop_inc_s;
                            state_d = RECV;
                        end else begin
                            state_d  = TRIG;
                            trig_d   = 1'b1;
                            tvalid_d = 1'b1;
                            tlast_d  = 1'b0;
                            tdata_d  = mem_q[FIRST_PTR];
                            rd_d     = FIRST_PTR;
                            src_ip_d = src_sh_q;
                        end
                    end else if (fail_s) begin
                        state_d = DROP;
                    end else begin
                        state_d = RECV;
                    end
                end else begin
                    state_d = RECV;
                end
            end
            DROP: begin
                if (accept_s && IP_RX_TLAST) begin
                    cnt_d   = 16'd0;
                    drop_d  = drop_inc_s;
                    state_d = RECV;
                end else if (accept_s) begin
                    cnt_d = cnt_inc_s;
                end else begin
                    state_d = DROP;
                end
            end
            TRIG, DRAIN: begin
                state_d = DRAIN;
                if (xfer_s && tlast_q) begin
                    state_d  = RECV;
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                    tdata_d  = 8'h00;
                    rd_d     = FIRST_PTR;
                    sum_d    = 32'd0;
                end else if (xfer_s) begin
                    rd_d    = rd_next_s;
                    tdata_d = mem_q[rd_next_s];
                    tlast_d = (rd_next_s == LAST_PTR);
                end else begin
                    rd_d = rd_q;
                end
            end
            default: state_d = RECV;
        endcase
        rdy_d = (state_d == RECV) || (state_d == DROP);
    end

    // Control, datapath and output registers
    always_ff @(posedge CLK_125M) begin
        if (SYS_RST) begin
            state_q  <= RECV;
            cnt_q    <= 16'd0;
            hi_q     <= 8'h00;
            sum_q    <= 32'd0;
            src_sh_q <= 32'd0;
            src_ip_q <= 32'd0;
            drop_q   <= 16'd0;
            rdy_q    <= 1'b0;
            trig_q   <= 1'b0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= 8'h00;
            rd_q     <= '0;
`ifdef ICMP_RX_IP_CKS_CHECK_EN
            csum_q   <= 16'd0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            sum_q    <= sum_d;
            src_sh_q <= src_sh_d;
            src_ip_q <= src_ip_d;
            drop_q   <= drop_d;
            rdy_q    <= rdy_d;
            trig_q   <= trig_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
            rd_q     <= rd_d;
`ifdef ICMP_RX_IP_CKS_CHECK_EN
            csum_q   <= csum_d;
`endif
        end
    end

    // Reply buffer write port
    always_ff @(posedge CLK_125M) begin
        if (SYS_RST) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[IDX_W'(i)] <= 8'h00;
            end
        end else if (wr_en_s) begin
            mem_q[wr_idx_s] <= IP_RX_TDATA;
        end else begin
            mem_q[wr_idx_s] <= mem_q[wr_idx_s];
        end
    end

    assign IP_RX_TREADY   = rdy_q;
    assign TRIG_TX_ICMP   = trig_q;
    assign RX_ICMP_TDATA  = tdata_q;
    assign RX_ICMP_TVALID = tvalid_q;
    assign RX_ICMP_TLAST  = tlast_q;
    assign RX_ICMP_TUSER  = sum_q;
    assign RX_ICMP_SRC_IP = src_ip_q;
    assign DROP_CNT       = drop_q;

endmodule
